// File: rtl/regfile_pkg.sv
// Shared types and constants for the 32 x 64-bit architectural register file.
package regfile_pkg;

    localparam int DATA_W    = 64;
    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [DATA_W-1:0]    word_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = 5'd31;

    // 5:32 one-hot write decoder; no enable at all when the port is idle,
    // and the XZR leg is never enabled so writes to it vanish.
    function automatic logic [NUM_REGS-1:0] decode5_32(input reg_idx_t idx,
                                                      input logic     en);
        logic [NUM_REGS-1:0] onehot;
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
        onehot[ZERO_REG] = 1'b0;
        return onehot;
    endfunction

endpackage

// File: rtl/regfile_mux32_1.sv
// 32:1 word selector built as a five-level tree of 2:1 multiplexers.
// Select bit 0 steers the leaf level, bit 4 the root.
module mux32_1
    import regfile_pkg::*;
(
    input  word_t    din [NUM_REGS],
    input  reg_idx_t sel,
    output word_t    dout
);

    word_t lvl1 [16];
    word_t lvl2 [8];
    word_t lvl3 [4];
    word_t lvl4 [2];

    // Leaf level: pair adjacent inputs on sel[0]
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            lvl1[i] = sel[0] ? din[2*i+1] : din[2*i];
        end
    end

    // Second level on sel[1]
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lvl2[i] = sel[1] ? lvl1[2*i+1] : lvl1[2*i];
        end
    end

    // Third level on sel[2]
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lvl3[i] = sel[2] ? lvl2[2*i+1] : lvl2[2*i];
        end
    end

    // Fourth level on sel[3]
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lvl4[i] = sel[3] ? lvl3[2*i+1] : lvl3[2*i];
        end
    end

    // Root on sel[4]
    always_comb begin
        dout = sel[4] ? lvl4[1] : lvl4[0];
    end

endmodule

// File: rtl/regfile.sv
// Architectural register file X0-X31: one write port, two independent
// combinational read ports, X31 hard-wired to zero. Writes commit on the
// clock edge with no bypass to the read ports.
module regfile
    import regfile_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic [4:0]  WriteRegister,
    input  logic [63:0] WriteData,
    input  logic [4:0]  ReadRegister1,
    input  logic [4:0]  ReadRegister2,
    output logic [63:0] ReadData1,
    output logic [63:0] ReadData2
);

    logic [NUM_REGS-1:0] wr_en;
    word_t               regs_q [NUM_REGS-1];
    word_t               regs_d [NUM_REGS-1];
    word_t               rd_legs [NUM_REGS];
    word_t               rd1;
    word_t               rd2;

    // Decode the write index into per-register load enables
    always_comb begin
        wr_en = decode5_32(WriteRegister, RegWrite);
    end

    // Storage for X0-X30: each word is an enabled register (hold/load mux
    // in front of a synchronously cleared flop). Reset wins over a load.
    for (genvar r = 0; r < NUM_REGS - 1; r++) begin : g_store

        // Hold unless this register is the decoded write target
        always_comb begin
            regs_d[r] = wr_en[r] ? word_t'(WriteData) : regs_q[r];
        end

        // Commit the next value, or clear on reset
        always_ff @(posedge clk) begin
            if (reset) begin
                regs_q[r] <= '0;
            end else begin
                regs_q[r] <= regs_d[r];
            end
        end

        assign rd_legs[r] = regs_q[r];
    end

    // XZR has no storage; its mux leg is a constant zero
    assign rd_legs[ZERO_REG] = '0;

    mux32_1 u_rd1_mux (
        .din  (rd_legs),
        .sel  (reg_idx_t'(ReadRegister1)),
        .dout (rd1)
    );

    mux32_1 u_rd2_mux (
        .din  (rd_legs),
        .sel  (reg_idx_t'(ReadRegister2)),
        .dout (rd2)
    );

    assign ReadData1 = rd1;
    assign ReadData2 = rd2;

endmodule

// File: tb/tb_regfile.sv
// Directed testbench for the regfile block.
module tb_regfile;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    int total;
    int bad;

    regfile dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and land 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [63:0] val);
        RegWrite      = 1'b1;
        WriteRegister = idx;
        WriteData     = val;
        step();
        RegWrite      = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        RegWrite = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(31 - i);
            #1;
            total++;
            if (ReadData1 !== 64'h0) begin
                bad++;
                $display("FAIL reset_rd1[%0d]: got %h want %h", i, ReadData1, 64'h0);
            end
            total++;
            if (ReadData2 !== 64'h0) begin
                bad++;
                $display("FAIL reset_rd2[%0d]: got %h want %h", 31 - i, ReadData2, 64'h0);
            end
        end
    endtask

    task automatic test_write_readback();
        logic [63:0] exp;
        for (int i = 0; i < 31; i++) begin
            write_reg(5'(i), 64'hA5A5_0000_0000_0000 + 64'(i));
        end
        for (int i = 0; i < 31; i++) begin
            exp = 64'hA5A5_0000_0000_0000 + 64'(i);
            ReadRegister1 = 5'(i);
            ReadRegister2 = 5'(30 - i);
            #1;
            total++;
            if (ReadData1 !== exp) begin
                bad++;
                $display("FAIL wr_rd1[%0d]: got %h want %h", i, ReadData1, exp);
            end
            total++;
            if (ReadData2 !== 64'hA5A5_0000_0000_0000 + 64'(30 - i)) begin
                bad++;
                $display("FAIL wr_rd2[%0d]: got %h want %h", 30 - i, ReadData2,
                         64'hA5A5_0000_0000_0000 + 64'(30 - i));
            end
        end
        ReadRegister1 = 5'd5;
        ReadRegister2 = 5'd5;
        #1;
        total++;
        if (ReadData1 !== ReadData2 || ReadData1 !== 64'hA5A5_0000_0000_0005) begin
            bad++;
            $display("FAIL same_index: got %h/%h want %h", ReadData1, ReadData2,
                     64'hA5A5_0000_0000_0005);
        end
    endtask

    task automatic test_zero_reg();
        write_reg(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        ReadRegister1 = 5'd31;
        ReadRegister2 = 5'd30;
        #1;
        total++;
        if (ReadData1 !== 64'h0) begin
            bad++;
            $display("FAIL xzr_read: got %h want %h", ReadData1, 64'h0);
        end
        total++;
        if (ReadData2 !== 64'hA5A5_0000_0000_001E) begin
            bad++;
            $display("FAIL xzr_side_x30: got %h want %h", ReadData2, 64'hA5A5_0000_0000_001E);
        end
    endtask

    task automatic test_no_bypass();
        write_reg(5'd5, 64'h1111);
        RegWrite      = 1'b1;
        WriteRegister = 5'd5;
        WriteData     = 64'h2222;
        ReadRegister1 = 5'd5;
        ReadRegister2 = 5'd5;
        #1;
        total++;
        if (ReadData1 !== 64'h1111) begin
            bad++;
            $display("FAIL bypass_before: got %h want %h", ReadData1, 64'h1111);
        end
        step();
        RegWrite = 1'b0;
        #1;
        total++;
        if (ReadData2 !== 64'h2222) begin
            bad++;
            $display("FAIL bypass_after: got %h want %h", ReadData2, 64'h2222);
        end
    endtask

    task automatic test_regwrite_low();
        write_reg(5'd7, 64'h0000_0000_0000_0007);
        RegWrite      = 1'b0;
        WriteRegister = 5'd7;
        WriteData     = 64'hDEAD;
        ReadRegister1 = 5'd7;
        for (int c = 0; c < 3; c++) begin
            step();
            total++;
            if (ReadData1 !== 64'h0000_0000_0000_0007) begin
                bad++;
                $display("FAIL hold_x7[%0d]: got %h want %h", c, ReadData1, 64'h7);
            end
        end
    endtask

    task automatic test_back_to_back();
        RegWrite      = 1'b1;
        WriteRegister = 5'd9;
        WriteData     = 64'h0123_4567_89AB_CDEF;
        ReadRegister1 = 5'd9;
        step();
        total++;
        if (ReadData1 !== 64'h0123_4567_89AB_CDEF) begin
            bad++;
            $display("FAIL b2b_first: got %h want %h", ReadData1, 64'h0123_4567_89AB_CDEF);
        end
        WriteData = 64'hFEDC_BA98_7654_3210;
        step();
        RegWrite = 1'b0;
        total++;
        if (ReadData1 !== 64'hFEDC_BA98_7654_3210) begin
            bad++;
            $display("FAIL b2b_second: got %h want %h", ReadData1, 64'hFEDC_BA98_7654_3210);
        end
        ReadRegister2 = 5'd8;
        #1;
        total++;
        if (ReadData2 !== 64'hA5A5_0000_0000_0008) begin
            bad++;
            $display("FAIL b2b_neighbor: got %h want %h", ReadData2, 64'hA5A5_0000_0000_0008);
        end
    endtask

    task automatic test_reset_vs_write();
        reset         = 1'b1;
        RegWrite      = 1'b1;
        WriteRegister = 5'd3;
        WriteData     = 64'hBEEF;
        ReadRegister1 = 5'd3;
        ReadRegister2 = 5'd7;
        step();
        reset    = 1'b0;
        RegWrite = 1'b0;
        #1;
        total++;
        if (ReadData1 !== 64'h0) begin
            bad++;
            $display("FAIL rst_wins_x3: got %h want %h", ReadData1, 64'h0);
        end
        total++;
        if (ReadData2 !== 64'h0) begin
            bad++;
            $display("FAIL rst_clears_x7: got %h want %h", ReadData2, 64'h0);
        end
        write_reg(5'd3, 64'hBEEF);
        total++;
        if (ReadData1 !== 64'hBEEF) begin
            bad++;
            $display("FAIL post_rst_write: got %h want %h", ReadData1, 64'hBEEF);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset         = 1'b0;
        RegWrite      = 1'b0;
        WriteRegister = 5'd0;
        WriteData     = 64'h0;
        ReadRegister1 = 5'd0;
        ReadRegister2 = 5'd0;
        step();
        test_reset();
        test_write_readback();
        test_zero_reg();
        test_no_bypass();
        test_regwrite_low();
        test_back_to_back();
        test_reset_vs_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
